// File: rtl/amo_mem_unit.sv
// amo_mem_unit: memory-side responder for RISC-V A-extension requests.
// Runs one LR/SC/AMO at a time as an indivisible read-modify-write on a
// word-wide memory port and returns the old word, the SC status or an error.
// Optional feature macro: AMO_RESERVATION_EN enables the LR/SC reservation
// register and the snoop clear logic. Without it, LR is a plain load and
// SC always fails without touching memory.
module amo_mem_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        snoop_wr_valid,
  input  logic [31:0] snoop_wr_addr
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RSP  = 2'd3
  } state_e;

  state_e      state_q;
  logic [4:0]  op_q;
  logic [31:0] data_q;
  logic [31:0] old_q;

  logic        req_err_s;
  logic        sc_ok_s;

  // Returns 1 for every funct5 encoding this unit implements.
  function automatic logic op_supported(input logic [4:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SWAP, OP_LR, OP_SC, OP_XOR, OP_OR, OP_AND,
      OP_MIN, OP_MAX, OP_MINU, OP_MAXU: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // New memory word from the rs2 operand s and the old memory word.
  function automatic logic [31:0] amo_alu(input logic [4:0] op,
                                          input logic [31:0] s,
                                          input logic [31:0] old);
    logic [31:0] r;
    case (op)
      OP_ADD:  r = s + old;
      OP_SWAP: r = s;
      OP_XOR:  r = s ^ old;
      OP_OR:   r = s | old;
      OP_AND:  r = s & old;
      OP_MIN:  r = ($signed(s) < $signed(old)) ? s : old;
      OP_MAX:  r = ($signed(s) > $signed(old)) ? s : old;
      OP_MINU: r = (s < old) ? s : old;
      OP_MAXU: r = (s > old) ? s : old;
      default: r = s;
    endcase
    return r;
  endfunction

  assign req_err_s = (req_addr[1:0] != 2'b00) || !op_supported(req_op);

`ifdef AMO_RESERVATION_EN
  logic        res_valid_q;
  logic        res_valid_d;
  logic [29:0] res_addr_q;
  logic [29:0] res_addr_d;
  logic        res_valid_s;
  logic        snoop_res_s;
  logic        snoop_req_s;
  logic        lr_set_s;
  logic        sc_fail_s;
  logic        wr_done_s;
  logic [1:0]  unused_snoop_lsb_s;

  assign unused_snoop_lsb_s = snoop_wr_addr[1:0];
  // A snoop hitting the reserved word kills it in the same cycle, so the
  // SC decision sees the post-snoop reservation.
  assign snoop_res_s = snoop_wr_valid && (snoop_wr_addr[31:2] == res_addr_q);
  assign snoop_req_s = snoop_wr_valid && (snoop_wr_addr[31:2] == mem_addr[31:2]);
  assign res_valid_s = res_valid_q && !snoop_res_s;
  assign sc_ok_s     = res_valid_s && (res_addr_q == req_addr[31:2]);
  assign lr_set_s    = (state_q == S_RD) && mem_ack && (op_q == OP_LR);
  assign sc_fail_s   = (state_q == S_IDLE) && req_valid && !req_err_s &&
                       (req_op == OP_SC) && !sc_ok_s;
  assign wr_done_s   = (state_q == S_WR) && mem_ack;

  // Reservation next state: LR sets (unless snooped the same cycle); failed
  // SC, completed write to the reserved word and matching snoops clear.
  always_comb begin
    res_valid_d = res_valid_q;
    res_addr_d  = res_addr_q;
    if (lr_set_s) begin
      res_addr_d  = mem_addr[31:2];
      res_valid_d = !snoop_req_s;
    end else if (sc_fail_s || snoop_res_s ||
                 (wr_done_s && (mem_addr[31:2] == res_addr_q))) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // Reservation register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_addr_q  <= 30'd0;
    end else begin
      res_valid_q <= res_valid_d;
      res_addr_q  <= res_addr_d;
    end
  end
`else
  logic [32:0] unused_snoop_s;

  assign unused_snoop_s = {snoop_wr_valid, snoop_wr_addr};
  assign sc_ok_s        = 1'b0;
`endif

  // Request FSM with registered handshake, response and memory outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 5'd0;
      data_q    <= 32'd0;
      old_q     <= 32'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_err   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            data_q    <= req_data;
            mem_addr  <= {req_addr[31:2], 2'b00};
            req_ready <= 1'b0;
            if (req_err_s) begin
              state_q   <= S_RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 32'd0;
            end else if (req_op == OP_SC) begin
              if (sc_ok_s) begin
                state_q   <= S_WR;
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_wdata <= req_data;
              end else begin
                state_q   <= S_RSP;
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_data  <= 32'd1;
              end
            end else begin
              state_q <= S_RD;
              mem_en  <= 1'b1;
              mem_we  <= 1'b0;
            end
          end
        end
        S_RD: begin
          if (mem_ack) begin
            old_q <= mem_rdata;
            if (op_q == OP_LR) begin
              state_q   <= S_RSP;
              mem_en    <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_data  <= mem_rdata;
            end else begin
              state_q   <= S_WR;
              mem_we    <= 1'b1;
              mem_wdata <= amo_alu(op_q, data_q, mem_rdata);
            end
          end
        end
        S_WR: begin
          if (mem_ack) begin
            state_q   <= S_RSP;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= (op_q == OP_SC) ? 32'd0 : old_q;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            state_q   <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amo_mem_unit.sv
// Self-checking bench for amo_mem_unit: behavioural memory with programmable
// wait states, scoreboard queue of expected responses, one task per scenario.
module tb_amo_mem_unit;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;

`ifdef AMO_RESERVATION_EN
  localparam bit RES_EN = 1'b1;
`else
  localparam bit RES_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        snoop_wr_valid;
  logic [31:0] snoop_wr_addr;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] mem [logic [29:0]];
  int          wait_cycles = 0;
  int          wcnt = 0;
  int          wr_count = 0;
  int          en_cycles = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  amo_mem_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .snoop_wr_valid (snoop_wr_valid),
    .snoop_wr_addr  (snoop_wr_addr)
  );

  // Memory responder: after wait_cycles idle cycles acknowledge the access.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_en === 1'b1 && rst_n === 1'b1) begin
        if (wcnt >= wait_cycles) begin
          mem_ack = 1'b1;
          if (mem_we === 1'b1) begin
            mem[mem_addr[31:2]] = mem_wdata;
            wr_count++;
          end else begin
            mem_rdata = mem.exists(mem_addr[31:2]) ? mem[mem_addr[31:2]] : 32'd0;
          end
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  // Counts cycles in which the unit requests memory.
  always @(posedge clk) begin
    if (mem_en === 1'b1) en_cycles <= en_cycles + 1;
  end

  // Watchdog against a hung run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_amo(input logic [4:0] op,
                                            input logic [31:0] s,
                                            input logic [31:0] m);
    logic [31:0] r;
    case (op)
      OP_ADD:  r = m + s;
      OP_SWAP: r = s;
      OP_XOR:  r = m ^ s;
      OP_OR:   r = m | s;
      OP_AND:  r = m & s;
      OP_MIN:  r = ($signed(m) <= $signed(s)) ? m : s;
      OP_MAX:  r = ($signed(m) >= $signed(s)) ? m : s;
      OP_MINU: r = (m <= s) ? m : s;
      OP_MAXU: r = (m >= s) ? m : s;
      default: r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a[31:2]) ? mem[a[31:2]] : 32'd0;
  endfunction

  task automatic snoop(input logic [31:0] a);
    snoop_wr_valid = 1'b1;
    snoop_wr_addr  = a;
    @(posedge clk); #1;
    snoop_wr_valid = 1'b0;
  endtask

  // Issues one request, scoreboards the response, latency, address stability
  // and, when hold>0, output stability under rsp_ready back-pressure.
  task automatic do_req(input logic [4:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_data,
                        input logic exp_err, input int exp_lat, input int hold,
                        input string name);
    int          lat;
    logic        addr_ok;
    rsp_t        e;
    logic [31:0] held_d;
    logic        held_e;
    exp_q.push_back(rsp_t'{data: exp_data, err: exp_err});
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready: got %b expected 1", name, req_ready);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s busy: req_ready got %b expected 0", name, req_ready);
    end
    lat     = 1;
    addr_ok = 1'b1;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      if (mem_en === 1'b1 && mem_addr !== {addr[31:2], 2'b00}) addr_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!addr_ok) begin
      failures++;
      $display("FAIL %s mem_addr: not stable at %h", name, {addr[31:2], 2'b00});
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    e = exp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_err !== e.err) begin
      failures++;
      $display("FAIL %s response: got v=%b data=%h err=%b expected v=1 data=%h err=%b",
               name, rsp_valid, rsp_data, rsp_err, e.data, e.err);
    end
    held_d = rsp_data;
    held_e = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== held_d || rsp_err !== held_e ||
          mem_en !== 1'b0) begin
        failures++;
        $display("FAIL %s hold: got v=%b data=%h err=%b en=%b expected v=1 data=%h err=%b en=0",
                 name, rsp_valid, rsp_data, rsp_err, mem_en, held_d, held_e);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s release: got v=%b ready=%b expected v=0 ready=1",
               name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    req_op         = 5'd0;
    req_addr       = 32'd0;
    req_data       = 32'd0;
    rsp_ready      = 1'b0;
    snoop_wr_valid = 1'b0;
    snoop_wr_addr  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
        mem_en !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got ready=%b v=%b err=%b en=%b we=%b expected 1 0 0 0 0",
               req_ready, rsp_valid, rsp_err, mem_en, mem_we);
    end
    checks++;
    if (rsp_data !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_data: got data=%h addr=%h wdata=%h expected all 0",
               rsp_data, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_amo_add();
    mem[32'h100 >> 2] = 32'd5;
    do_req(OP_ADD, 32'h100, 32'd3, 32'd5, 1'b0, 3, 0, "amoadd");
    checks++;
    if (rd_mem(32'h100) !== 32'd8) begin
      failures++;
      $display("FAIL amoadd_mem: got %h expected 00000008", rd_mem(32'h100));
    end
  endtask

  task automatic test_min_minu();
    mem[32'h300 >> 2] = 32'hFFFF_FFFF;
    do_req(OP_MIN, 32'h300, 32'd1, 32'hFFFF_FFFF, 1'b0, 3, 0, "amomin");
    checks++;
    if (rd_mem(32'h300) !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL amomin_mem: got %h expected ffffffff", rd_mem(32'h300));
    end
    mem[32'h300 >> 2] = 32'hFFFF_FFFF;
    do_req(OP_MINU, 32'h300, 32'd1, 32'hFFFF_FFFF, 1'b0, 3, 0, "amominu");
    checks++;
    if (rd_mem(32'h300) !== 32'd1) begin
      failures++;
      $display("FAIL amominu_mem: got %h expected 00000001", rd_mem(32'h300));
    end
  endtask

  task automatic test_amo_ops();
    logic [4:0]  ops [8] = '{OP_SWAP, OP_XOR, OP_OR, OP_AND, OP_MAX, OP_MAXU, OP_ADD, OP_MIN};
    logic [31:0] m;
    logic [31:0] s;
    for (int i = 0; i < 8; i++) begin
      m = $urandom;
      s = $urandom;
      if (i == 6) begin
        m = 32'hFFFF_FFFF;
        s = 32'd2;
      end
      mem[32'h700 >> 2] = m;
      do_req(ops[i], 32'h700, s, m, 1'b0, 3, 0, "amo_op");
      checks++;
      if (rd_mem(32'h700) !== model_amo(ops[i], s, m)) begin
        failures++;
        $display("FAIL amo_op_mem op=%b: got %h expected %h",
                 ops[i], rd_mem(32'h700), model_amo(ops[i], s, m));
      end
    end
  endtask

  task automatic test_lr_sc();
    int wc;
    mem[32'h200 >> 2] = 32'h55;
    do_req(OP_LR, 32'h200, 32'd0, 32'h55, 1'b0, 2, 0, "lr");
    do_req(OP_SC, 32'h200, 32'hAA, RES_EN ? 32'd0 : 32'd1, 1'b0,
           RES_EN ? 2 : 1, 0, "sc_first");
    checks++;
    if (rd_mem(32'h200) !== (RES_EN ? 32'hAA : 32'h55)) begin
      failures++;
      $display("FAIL sc_first_mem: got %h expected %h", rd_mem(32'h200),
               RES_EN ? 32'hAA : 32'h55);
    end
    wc = wr_count;
    do_req(OP_SC, 32'h200, 32'hCC, 32'd1, 1'b0, 1, 0, "sc_second");
    checks++;
    if (wr_count != wc || rd_mem(32'h200) === 32'hCC) begin
      failures++;
      $display("FAIL sc_second_nowrite: got writes=%0d expected %0d", wr_count, wc);
    end
  endtask

  task automatic test_snoop();
    mem[32'h200 >> 2] = 32'h11;
    do_req(OP_LR, 32'h200, 32'd0, 32'h11, 1'b0, 2, 0, "lr_s1");
    snoop(32'h204);
    do_req(OP_SC, 32'h200, 32'hBB, RES_EN ? 32'd0 : 32'd1, 1'b0,
           RES_EN ? 2 : 1, 0, "sc_other_word");
    do_req(OP_LR, 32'h200, 32'd0, RES_EN ? 32'hBB : 32'h11, 1'b0, 2, 0, "lr_s2");
    snoop(32'h202);
    do_req(OP_SC, 32'h200, 32'hEE, 32'd1, 1'b0, 1, 0, "sc_snooped");
    do_req(OP_LR, 32'h200, 32'd0, RES_EN ? 32'hBB : 32'h11, 1'b0, 2, 0, "lr_s3");
    snoop_wr_valid = 1'b1;
    snoop_wr_addr  = 32'h200;
    do_req(OP_SC, 32'h200, 32'hEE, 32'd1, 1'b0, 1, 0, "sc_same_cycle");
    snoop_wr_valid = 1'b0;
    checks++;
    if (rd_mem(32'h200) !== (RES_EN ? 32'hBB : 32'h11)) begin
      failures++;
      $display("FAIL snoop_mem: got %h expected %h", rd_mem(32'h200),
               RES_EN ? 32'hBB : 32'h11);
    end
  endtask

  task automatic test_errors();
    int en0;
    en0 = en_cycles;
    do_req(OP_SWAP, 32'h101, 32'h1234, 32'd0, 1'b1, 1, 0, "misaligned");
    do_req(5'b00101, 32'h100, 32'h1234, 32'd0, 1'b1, 1, 0, "bad_op");
    checks++;
    if (en_cycles != en0) begin
      failures++;
      $display("FAIL err_no_access: got %0d mem_en cycles expected 0", en_cycles - en0);
    end
  endtask

  task automatic test_back_pressure();
    wait_cycles = 4;
    mem[32'h400 >> 2] = 32'd10;
    do_req(OP_ADD, 32'h400, 32'd20, 32'd10, 1'b0, 11, 3, "slow_add");
    wait_cycles = 0;
    checks++;
    if (rd_mem(32'h400) !== 32'd30) begin
      failures++;
      $display("FAIL slow_add_mem: got %h expected 0000001e", rd_mem(32'h400));
    end
  endtask

  task automatic test_reset_mid();
    int wc;
    int n;
    mem[32'h600 >> 2] = 32'h66;
    mem[32'h500 >> 2] = 32'd7;
    do_req(OP_LR, 32'h600, 32'd0, 32'h66, 1'b0, 2, 0, "lr_pre_reset");
    wait_cycles = 4;
    wc = wr_count;
    req_valid = 1'b1;
    req_op    = OP_ADD;
    req_addr  = 32'h500;
    req_data  = 32'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (mem_we !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (mem_we !== 1'b1 || mem_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_wr: got en=%b we=%b expected 1 1", mem_en, mem_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_drop: got en=%b we=%b v=%b expected 0 0 0",
               mem_en, mem_we, rsp_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_cycles = 0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_en !== 1'b0 ||
        wr_count != wc || rd_mem(32'h500) !== 32'd7) begin
      failures++;
      $display("FAIL reset_mid_idle: got ready=%b v=%b en=%b mem=%h expected 1 0 0 00000007",
               req_ready, rsp_valid, mem_en, rd_mem(32'h500));
    end
    do_req(OP_SC, 32'h600, 32'h99, 32'd1, 1'b0, 1, 0, "sc_after_reset");
  endtask

  initial begin
    test_reset();
    test_amo_add();
    test_min_minu();
    test_amo_ops();
    test_lr_sc();
    test_snoop();
    test_errors();
    test_back_pressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/amo_mem_unit.md
# amo_mem_unit

Memory-side responder for RISC-V A-extension requests. It accepts one atomic request at a time from the core's data port and performs the read-modify-write against a word-wide memory port. It also holds the LR/SC reservation and returns the original memory word, the SC status, or an error. It sits between the core's AMO issue logic and the data memory/bus, so an AMO is indivisible from the memory's point of view.

## Interface
- Parameters: none. Data and address width is the global `XLEN` (32).
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request
- `req_op`  in  5  funct5:
  - ADD=00000, SWAP=00001, LR=00010, SC=00011, XOR=00100
  - OR=01000, AND=01100, MIN=10000, MAX=10100, MINU=11000, MAXU=11100
- `req_addr`  in  XLEN  byte address
- `req_data`  in  XLEN  rs2 operand
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  core takes the response
- `rsp_data`  out  XLEN  result word
- `rsp_err`  out  1  misaligned address or unsupported op
- `mem_en`  out  1  memory access request
- `mem_we`  out  1  1 = write
- `mem_addr`  out  XLEN  word-aligned address
- `mem_wdata`  out  XLEN  write data
- `mem_rdata`  in  XLEN  read data, valid with `mem_ack`
- `mem_ack`  in  1  access complete (0..N wait cycles)
- `snoop_wr_valid`  in  1  another master wrote memory
- `snoop_wr_addr`  in  XLEN  address of that write

## Operation
- FSM states: IDLE, RD, WR, RSP.
- IDLE:
  - `req_ready`=1; all other request lines are 0.
  - On handshake, capture op, addr and data.
  - Misaligned address (`addr[1:0]`≠0) or an op not listed above: go to RSP with `rsp_err`=1 and `rsp_data`=0. No memory access.
  - SC: with a valid reservation whose `addr[XLEN-1:2]` matches, go to WR. Otherwise go to RSP with `rsp_data`=1.
  - Any other op: go to RD.
- RD:
  - `mem_en`=1, `mem_we`=0; hold until `mem_ack`.
  - On ack, latch `mem_rdata` as `old`.
  - LR: set the reservation to this word, then go to RSP.
  - Other ops: go to WR.
- WR:
  - `mem_en`=1, `mem_we`=1; hold until `mem_ack`.
  - `mem_wdata` = f(`req_data`, `old`):
    - SWAP: s
    - ADD: s+old, mod 2^XLEN
    - XOR / AND / OR: bitwise
    - MIN / MAX: signed compare
    - MINU / MAXU: unsigned compare
    - SC: s
  - On ack: for SC, clear the reservation and set `rsp_data`=0; for AMOs, `rsp_data`=`old`. Then go to RSP.
- RSP: `rsp_valid`=1, outputs held stable until `rsp_ready`, then go to IDLE.
- Reservation rules:
  - A failed SC also clears the reservation.
  - A completed AMO write to the reserved word clears it.
  - `snoop_wr_valid` with a matching word address clears it in any state.
  - In the same cycle, snoop-clear beats an LR set: the reservation stays invalid.
  - The SC decision in IDLE samples the reservation after that cycle's snoop, so a same-cycle snoop makes SC fail.
- `mem_addr` = `{addr[XLEN-1:2],2'b00}`, stable throughout RD and WR.

## Timing
- Reset (asynchronous):
  - state=IDLE, reservation invalid.
  - `req_ready`=1 after reset; `rsp_valid`, `rsp_err`, `mem_en` and `mem_we` =0.
  - `rsp_data`, `mem_addr` and `mem_wdata` =0.
- Reset mid-operation drops `mem_en` immediately. No response is produced and the in-flight access is abandoned.
- Latencies, with zero-wait memory (`mem_ack` in the first cycle of RD/WR), counting edges after the accept edge:
  - AMO: `rsp_valid` at edge 3.
  - LR: edge 2.
  - SC success: edge 2.
  - SC fail or error: edge 1.
- Each memory wait cycle adds one cycle. `mem_*` outputs are registered-state decodes, glitch-free.
- Only one request is outstanding; `req_ready`=0 from the accept edge until return to IDLE.

## Configuration
- `AMO_RESERVATION_EN` defined:
  - Reservation register and snoop logic present.
  - LR/SC behave as described above.
- `AMO_RESERVATION_EN` undefined:
  - No reservation state; the snoop inputs are ignored.
  - LR behaves as a plain load (RD→RSP, `rsp_data`=word).
  - SC always fails: `rsp_data`=1, no memory access, one-cycle response.
  - All AMOs are unchanged.

## Test plan
- AMOADD: mem[0x100]=5, addr 0x100, data 3, zero-wait → write 8, `rsp_data`=5, `rsp_valid` at edge 3.
- AMOMIN vs AMOMINU: mem=0xFFFFFFFF, data 1:
  - MIN writes 0xFFFFFFFF;
  - MINU writes 1;
  - both return 0xFFFFFFFF.
- LR 0x200, then SC 0x200 data 0xAA → SC `rsp_data`=0, mem=0xAA. A second SC to 0x200 → 1, no write.
- LR 0x200, then snoop write 0x204 (no clear), then snoop 0x202 (clears), then SC 0x200 → 1. Snoop in the SC accept cycle → 1.
- Misaligned AMOSWAP at 0x101 → `rsp_err`=1 at edge 1, `mem_en` never asserted.
- Back-pressure and reset:
  - `mem_ack` delayed 4 cycles in both RD and WR → response at edge 11, `mem_addr` stable throughout.
  - `rsp_ready` held low 3 cycles → outputs stable.
  - `rst_n` low during WR → `mem_en`=0 immediately, then IDLE with reservation invalid.
